cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_pkg.sv | 38 +++
 rtl/cache_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// cache_ctrl_pkg: shared address-field bounds, width codes and FSM encoding for cache_ctrl.
// Revision 1.0
package cache_ctrl_pkg;

  localparam int ADDR_BITS_DEF     = 32;
  localparam int TAG_BITS_DEF      = 23;
  localparam int ELEMENT_WORDS_DEF = 4;

  // Byte offset within a word occupies the low two address bits.
  localparam int WORD_LO = 2;

  // Width code used for full-word line-fill writes into the cache.
  localparam logic [2:0] UBHW_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    CHECK   = 3'd2,
    WB_RD   = 3'd3,
    WB_WR   = 3'd4,
    FILL    = 3'd5
  } state_t;

  function automatic int word_bits(input int element_words);
    return $clog2(element_words);
  endfunction

  function automatic int index_lo(input int element_words);
    return WORD_LO + $clog2(element_words);
  endfunction

  function automatic int index_bits(input int addr_bits, input int tag_bits, input int element_words);
    return addr_bits - tag_bits - index_lo(element_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// cache_ctrl: blocking CPU-side controller for an external write-back cache; evicts dirty victims
// word by word, then fills the line from memory and retries the lookup. Revision 1.0
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_BITS     = ADDR_BITS_DEF,
  parameter int TAG_BITS      = TAG_BITS_DEF,
  parameter int ELEMENT_WORDS = ELEMENT_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_wen,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [2:0]           cpu_ubhw,
  input  logic [31:0]          cpu_din,
  output logic [31:0]          cpu_dout,
  output logic                 cpu_ready,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic                 cache_invalid,
  output logic [2:0]           cache_ubhw,
  output logic [31:0]          cache_din,
  input  logic [31:0]          cache_dout,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack
);

  localparam int WORD_BITS  = word_bits(ELEMENT_WORDS);
  localparam int INDEX_LO   = index_lo(ELEMENT_WORDS);
  localparam int INDEX_BITS = index_bits(ADDR_BITS, TAG_BITS, ELEMENT_WORDS);
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(ELEMENT_WORDS - 1);

  state_t                 state, state_nxt;
  logic [WORD_BITS-1:0]   cnt, cnt_nxt;
  logic [ADDR_BITS-1:0]   req_addr;
  logic                   req_wen;
  logic [2:0]             req_ubhw;
  logic [31:0]            req_din;
  logic [TAG_BITS-1:0]    victim_tag;
  logic                   accept;
  logic                   victim_capture;
  logic                   ready_nxt;
  logic [31:0]            dout_nxt;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [ADDR_BITS-1:0]   line_addr;
  logic [ADDR_BITS-1:0]   victim_addr;

  assign req_tag       = req_addr[ADDR_BITS-1 -: TAG_BITS];
  assign req_index     = req_addr[INDEX_LO +: INDEX_BITS];
  assign line_addr     = {req_tag, req_index, cnt, 2'b00};
  assign victim_addr   = {victim_tag, req_index, cnt, 2'b00};
  assign cache_invalid = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_wen    <= 1'b0;
      req_ubhw   <= '0;
      req_din    <= '0;
      victim_tag <= '0;
      cpu_ready  <= 1'b0;
      cpu_dout   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cpu_ready <= ready_nxt;
      cpu_dout  <= dout_nxt;
      if (accept) begin
        req_addr <= cpu_addr;
        req_wen  <= cpu_wen;
        req_ubhw <= cpu_ubhw;
        req_din  <= cpu_din;
      end
      if (victim_capture) begin
        victim_tag <= cache_tag;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    accept         = 1'b0;
    victim_capture = 1'b0;
    ready_nxt      = 1'b0;
    dout_nxt       = cpu_dout;
    cache_addr     = '0;
    cache_load     = 1'b0;
    cache_edit     = 1'b0;
    cache_store    = 1'b0;
    cache_ubhw     = '0;
    cache_din      = '0;
    mem_cs         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    case (state)
      IDLE: begin
        // A request still held during the ready pulse belongs to the finished access.
        if (cpu_req && !cpu_ready) begin
          accept    = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        cache_addr = req_addr;
        cache_load = ~req_wen;
        cache_edit = req_wen;
        cache_ubhw = req_ubhw;
        cache_din  = req_din;
        state_nxt  = CHECK;
      end
      CHECK: begin
        if (cache_hit) begin
          ready_nxt = 1'b1;
          dout_nxt  = cache_dout;
          state_nxt = IDLE;
        end else if (cache_valid && cache_dirty) begin
          victim_capture = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = WB_RD;
        end else begin
          cnt_nxt   = '0;
          state_nxt = FILL;
        end
      end
      WB_RD: begin
        cache_addr = line_addr;
        state_nxt  = WB_WR;
      end
      WB_WR: begin
        cache_addr = line_addr;
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = victim_addr;
        mem_wdata  = cache_dout;
        if (mem_ack) begin
          if (cnt == LAST_WORD) begin
            cnt_nxt   = '0;
            state_nxt = FILL;
          end else begin
            cnt_nxt   = cnt + WORD_BITS'(1);
            state_nxt = WB_RD;
          end
        end
      end
      FILL: begin
        cache_addr = line_addr;
        mem_cs     = 1'b1;
        mem_addr   = line_addr;
        if (mem_ack) begin
          cache_store = 1'b1;
          cache_ubhw  = UBHW_WORD;
          cache_din   = mem_rdata;
          cnt_nxt     = cnt + WORD_BITS'(1);
          // Retrying the lookup after the last word refreshes LRU and returns the data.
          if (cnt == LAST_WORD) begin
            state_nxt = COMPARE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// tb_cache_ctrl: scoreboard bench with a 2-way cache model and a delay-programmable memory model.
// Revision 1.0
module tb_cache_ctrl;

  localparam logic [2:0] LW = 3'b010;
  localparam logic [2:0] SB = 3'b000;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_wen;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic [2:0]  cpu_ubhw;
  logic        cpu_ready;
  logic [31:0] cache_addr, cache_din, cache_dout;
  logic        cache_load, cache_edit, cache_store, cache_invalid;
  logic [2:0]  cache_ubhw;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [22:0] cache_tag;
  logic        mem_cs, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_ubhw(cpu_ubhw),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
    .cache_store(cache_store), .cache_invalid(cache_invalid), .cache_ubhw(cache_ubhw),
    .cache_din(cache_din), .cache_dout(cache_dout), .cache_hit(cache_hit),
    .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int edit_cnt  = 0;
  int store_cnt = 0;
  int mem_delay;
  int wait_cnt;
  logic prev_ready;

  typedef struct { logic chk_data; logic [31:0] data; int lat; int t0; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } memx_t;
  rsp_t  exp_rsp[$];
  memx_t exp_mem[$];

  logic [22:0] c_tag  [32][2];
  logic        c_val  [32][2];
  logic        c_dirty[32][2];
  logic [31:0] c_data [32][2][4];
  logic        c_lru  [32];
  logic [31:0] mem    [4096];

  function automatic logic [11:0] midx(input logic [31:0] a);
    return {a[29:28], a[11:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Cache model: registered status/data, LRU victim reported on a miss.
  always @(posedge clk) begin : cache_model
    logic [4:0]  idx;
    logic [1:0]  w;
    logic [22:0] t;
    logic        hit, hw, v;
    logic [31:0] nw;
    idx = cache_addr[8:4];
    w   = cache_addr[3:2];
    t   = cache_addr[31:9];
    if (cache_load || cache_edit) begin
      hit = 1'b0;
      hw  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (c_val[idx][k] && c_tag[idx][k] == t) begin
          hit = 1'b1;
          hw  = k[0];
        end
      end
      cache_hit <= hit;
      if (hit) begin
        cache_dout <= c_data[idx][hw][w];
        c_lru[idx] <= ~hw;
        if (cache_edit) begin
          nw = c_data[idx][hw][w];
          case (cache_ubhw[1:0])
            2'b00:   nw[8*cache_addr[1:0] +: 8]  = cache_din[7:0];
            2'b01:   nw[16*cache_addr[1] +: 16]  = cache_din[15:0];
            default: nw = cache_din;
          endcase
          c_data[idx][hw][w] <= nw;
          c_dirty[idx][hw]   <= 1'b1;
        end
      end else begin
        v = c_lru[idx];
        cache_valid <= c_val[idx][v];
        cache_dirty <= c_dirty[idx][v];
        cache_tag   <= c_tag[idx][v];
      end
    end else if (cache_store) begin
      v = c_lru[idx];
      c_data[idx][v][w] <= cache_din;
      if (w == 2'd0) begin
        c_val[idx][v]   <= 1'b0;
        c_tag[idx][v]   <= t;
        c_dirty[idx][v] <= 1'b0;
      end
      if (w == 2'd3) c_val[idx][v] <= 1'b1;
    end else begin
      cache_dout <= c_data[idx][c_lru[idx]][w];
    end
  end

  // Memory model: one-cycle ack pulse per word after mem_delay cycles of mem_cs.
  always @(posedge clk) begin
    if (!rst) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if (mem_cs) begin
      if (wait_cnt >= mem_delay) begin
        mem_ack  <= 1'b1;
        wait_cnt <= 0;
        if (mem_we) mem[midx(mem_addr)] <= mem_wdata;
        else        mem_rdata <= mem[midx(mem_addr)];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  always @(negedge clk) begin : monitor
    rsp_t  r;
    memx_t m;
    if (!rst) begin
      prev_ready <= 1'b0;
    end else begin
      chk("strobe_onehot", 32'($countones({cache_load, cache_edit, cache_store}) <= 1), 32'd1);
      if (cache_edit) edit_cnt++;
      if (cache_store) begin
        store_cnt++;
        chk("store_din", cache_din, mem_rdata);
        chk("store_addr", cache_addr, mem_addr);
      end
      if (mem_cs && exp_mem.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_mem_cs actual=1 required=0 addr=0x%08h", mem_addr);
      end else if (mem_cs && mem_ack) begin
        m = exp_mem.pop_front();
        chk("mem_we", 32'(mem_we), 32'(m.we));
        chk("mem_addr", mem_addr, m.addr);
        if (m.we) chk("mem_wdata", mem_wdata, m.data);
      end
      if (cpu_ready) begin
        chk("ready_single", 32'(prev_ready), 32'd0);
        if (exp_rsp.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_ready actual=1 required=0");
        end else begin
          r = exp_rsp.pop_front();
          if (r.chk_data) chk("cpu_dout", cpu_dout, r.data);
          if (r.lat >= 0) chk("latency", 32'(cyc - r.t0), 32'(r.lat));
        end
      end
      prev_ready <= cpu_ready;
    end
  end

  task automatic exp_line(input logic we, input logic [31:0] base, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      memx_t m;
      m.we = we; m.addr = base + 32'(4 * i); m.data = d0 + 32'(i);
      exp_mem.push_back(m);
    end
  endtask

  task automatic preload_mem(input logic [31:0] base, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) mem[midx(base + 32'(4 * i))] <= d0 + 32'(i);
  endtask

  task automatic set_way(input int idx, input int way, input logic [22:0] tag,
                         input logic val, input logic dirty, input logic [31:0] d0);
    c_tag[idx][way]   <= tag;
    c_val[idx][way]   <= val;
    c_dirty[idx][way] <= dirty;
    for (int i = 0; i < 4; i++) c_data[idx][way][i] <= d0 + 32'(i);
  endtask

  // Called on a falling edge; the request is sampled on the next rising edge.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [2:0] ubhw,
                        input logic [31:0] din, input logic chk_data, input logic [31:0] exp_data,
                        input int lat);
    rsp_t r;
    logic done;
    r.chk_data = chk_data; r.data = exp_data; r.lat = lat; r.t0 = cyc + 1;
    exp_rsp.push_back(r);
    cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_ubhw = ubhw; cpu_din = din;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
    end
    cpu_req = 1'b0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL req_timeout addr=0x%08h actual=no_ready required=ready", addr);
      exp_rsp.delete();
      exp_mem.delete();
    end
    chk("mem_words_left", 32'(exp_mem.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   e0, s0;
    logic found;
    rst = 1'b0; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_ubhw = '0; cpu_din = '0;
    mem_delay = 0;
    for (int i = 0; i < 32; i++) begin
      c_lru[i] <= 1'b0;
      for (int k = 0; k < 2; k++) set_way(i, k, 23'd0, 1'b0, 1'b0, 32'd0);
    end
    for (int i = 0; i < 4096; i++) mem[i] <= 32'hDEAD_0000 + 32'(i);
    repeat (3) @(negedge clk);

    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_dout", cpu_dout, 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_cache_strobes", 32'({cache_load, cache_edit, cache_store, cache_invalid}), 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);
    rst = 1'b1;

    // Load hit on a preloaded line.
    set_way(4, 0, 23'd0, 1'b1, 1'b0, 32'h1122_3344);
    c_lru[4] <= 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h0000_0040, LW, 32'd0, 1'b1, 32'h1122_3344, 2);

    // Store-byte hit, then read back the merged word.
    e0 = edit_cnt;
    do_req(1'b1, 32'h0000_0041, SB, 32'h0000_00EF, 1'b0, 32'd0, 2);
    chk("store_edit_pulses", 32'(edit_cnt - e0), 32'd1);
    do_req(1'b0, 32'h0000_0040, LW, 32'd0, 1'b1, 32'h1122_EF44, 2);

    // Clean miss into an empty set.
    preload_mem(32'h1000_0020, 32'hA0);
    exp_line(1'b0, 32'h1000_0020, 32'd0);
    s0 = store_cnt;
    do_req(1'b0, 32'h1000_0020, LW, 32'd0, 1'b1, 32'hA0, 12);
    chk("clean_fill_stores", 32'(store_cnt - s0), 32'd4);

    // Dirty eviction: victim way 0 holds tag 0x5 at index 2.
    set_way(2, 0, 23'h5, 1'b1, 1'b1, 32'hC0);
    set_way(2, 1, 23'h6, 1'b1, 1'b0, 32'h60);
    c_lru[2] <= 1'b0;
    preload_mem(32'h0000_0E20, 32'hB0);
    @(negedge clk);
    exp_line(1'b1, 32'h0000_0A20, 32'hC0);
    exp_line(1'b0, 32'h0000_0E20, 32'd0);
    do_req(1'b0, 32'h0000_0E24, LW, 32'd0, 1'b1, 32'hB1, -1);

    // Slow memory: five wait cycles per word.
    mem_delay = 5;
    preload_mem(32'h2000_0030, 32'hD0);
    exp_line(1'b0, 32'h2000_0030, 32'd0);
    s0 = store_cnt;
    do_req(1'b0, 32'h2000_0034, LW, 32'd0, 1'b1, 32'hD1, -1);
    chk("slow_fill_stores", 32'(store_cnt - s0), 32'd4);
    mem_delay = 0;

    // Reset during the second fill ack, then reissue.
    preload_mem(32'h4000_0070, 32'hF0);
    exp_line(1'b0, 32'h4000_0070, 32'd0);
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h4000_0074; cpu_ubhw = LW; cpu_din = '0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (mem_cs && mem_ack && mem_addr[3:2] == 2'd1) found = 1'b1;
    end
    if (!found) begin
      checks++; fails++;
      $display("FAIL rst_wait_timeout actual=no_second_ack required=second_ack");
    end
    #1 rst = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("midfill_rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("midfill_rst_store", 32'(cache_store), 32'd0);
    chk("midfill_rst_mem_addr", mem_addr, 32'd0);
    exp_mem.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'({mem_cs, cache_load, cache_edit, cache_store, cpu_ready}), 32'd0);
    exp_line(1'b0, 32'h4000_0070, 32'd0);
    do_req(1'b0, 32'h4000_0074, LW, 32'd0, 1'b1, 32'hF1, 12);

    repeat (3) @(negedge clk);
    chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
